adc_scan_sequencer: RTL and testbench

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

---
 rtl/adc_scan_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
// Scan sequencer for an SPI ADC: walks the enabled channel list, issues one SPI
// frame per channel and stores the pipelined conversion results in a table.
module adc_scan_sequencer #(
  parameter int unsigned GAP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cont,
  input  logic [7:0]  ch_mask,
  output logic [15:0] mo_data,
  output logic        mo_load,
  input  logic        busy,
  input  logic [15:0] mi_data,
  output logic        result_valid,
  output logic [2:0]  result_ch,
  output logic [11:0] result_data,
  input  logic [2:0]  rd_addr,
  output logic [11:0] rd_data,
  output logic        scan_done,
  output logic        active,
  output logic        fault
);

  localparam int unsigned CH_W  = 3;
  localparam int unsigned RES_W = 12;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned N_CH  = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_XFER  = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [7:0]       mask_q, mask_d;
  logic [CH_W-1:0]  cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]  prev_ch_q, prev_ch_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             arm_cnt_q, arm_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             end_q, end_d;

  logic             mo_load_q, mo_load_d;
  logic [15:0]      mo_data_q, mo_data_d;
  logic             result_valid_q, result_valid_d;
  logic [CH_W-1:0]  result_ch_q, result_ch_d;
  logic [RES_W-1:0] result_data_q, result_data_d;
  logic             scan_done_q, scan_done_d;
  logic             active_q, active_d;
  logic             fault_q, fault_d;

  logic [RES_W-1:0] table_q [N_CH];
  logic             tbl_we;
  logic [CH_W-1:0]  tbl_waddr;
  logic [RES_W-1:0] tbl_wdata;
  logic             discard;
  logic             unused_mi;

  assign unused_mi = ^mi_data[15:12];

  function automatic logic [CH_W-1:0] lowest_ch(input logic [7:0] m);
    lowest_ch = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_ch = CH_W'(i);
    end
  endfunction

  function automatic logic [CH_W-1:0] highest_ch(input logic [7:0] m);
    highest_ch = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) highest_ch = CH_W'(i);
    end
  endfunction

  // Next enabled channel after cur, wrapping; a single-channel mask returns cur.
  function automatic logic [CH_W-1:0] next_ch(input logic [7:0] m, input logic [CH_W-1:0] cur);
    logic [CH_W-1:0] c;
    next_ch = cur;
    for (int k = 8; k >= 1; k--) begin
      c = cur + CH_W'(k);
      if (m[c]) next_ch = c;
    end
  endfunction

  // Only frame 0 of a first scan carries a stale result from an unknown address.
  assign discard = first_q && (idx_q == '0);

  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    cur_ch_d       = cur_ch_q;
    prev_ch_d      = prev_ch_q;
    first_d        = first_q;
    idx_d          = idx_q;
    arm_cnt_d      = arm_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    end_d          = end_q;
    result_valid_d = 1'b0;
    result_ch_d    = result_ch_q;
    result_data_d  = result_data_q;
    scan_done_d    = 1'b0;
    fault_d        = fault_q;
    tbl_we         = 1'b0;
    tbl_waddr      = prev_ch_q;
    tbl_wdata      = result_data_q;

    case (state_q)
      S_IDLE: begin
        if (start && (ch_mask != 8'h00)) begin
          mask_d   = ch_mask;
          fault_d  = 1'b0;
          idx_d    = '0;
          first_d  = 1'b1;
          cur_ch_d = lowest_ch(ch_mask);
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        arm_cnt_d = 1'b0;
        state_d   = S_ARM;
      end
      S_ARM: begin
        if (busy) begin
          state_d = S_XFER;
        end else if (arm_cnt_q) begin
          fault_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          arm_cnt_d = 1'b1;
        end
      end
      S_XFER: begin
        if (!busy) begin
          state_d = S_STORE;
          if (!discard) begin
            result_valid_d = 1'b1;
            result_ch_d    = prev_ch_q;
            result_data_d  = mi_data[RES_W-1:0];
          end
        end
      end
      S_STORE: begin
        tbl_we    = !discard;
        end_d     = !discard && (prev_ch_q == highest_ch(mask_q));
        idx_d     = idx_q + CNT_W'(1);
        gap_cnt_d = '0;
        state_d   = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == CNT_W'(GAP - 1)) begin
          if (!end_q) begin
            prev_ch_d = cur_ch_q;
            cur_ch_d  = next_ch(mask_q, cur_ch_q);
            state_d   = S_LOAD;
          end else begin
            scan_done_d = 1'b1;
            if (cont && (ch_mask != 8'h00)) begin
              idx_d   = '0;
              state_d = S_LOAD;
              // Same mask: the last c0 frame doubles as frame 0 of the next scan.
              if (ch_mask == mask_q) begin
                first_d   = 1'b0;
                prev_ch_d = cur_ch_q;
                cur_ch_d  = next_ch(mask_q, cur_ch_q);
              end else begin
                mask_d   = ch_mask;
                first_d  = 1'b1;
                cur_ch_d = lowest_ch(ch_mask);
              end
            end else begin
              state_d = S_IDLE;
            end
          end
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    mo_load_d = (state_d == S_LOAD);
    mo_data_d = {2'b00, cur_ch_d, 11'b0};
    active_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      mask_q         <= '0;
      cur_ch_q       <= '0;
      prev_ch_q      <= '0;
      first_q        <= 1'b0;
      idx_q          <= '0;
      arm_cnt_q      <= 1'b0;
      gap_cnt_q      <= '0;
      end_q          <= 1'b0;
      mo_load_q      <= 1'b0;
      mo_data_q      <= '0;
      result_valid_q <= 1'b0;
      result_ch_q    <= '0;
      result_data_q  <= '0;
      scan_done_q    <= 1'b0;
      active_q       <= 1'b0;
      fault_q        <= 1'b0;
      for (int i = 0; i < N_CH; i++) table_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      mask_q         <= mask_d;
      cur_ch_q       <= cur_ch_d;
      prev_ch_q      <= prev_ch_d;
      first_q        <= first_d;
      idx_q          <= idx_d;
      arm_cnt_q      <= arm_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      end_q          <= end_d;
      mo_load_q      <= mo_load_d;
      mo_data_q      <= mo_data_d;
      result_valid_q <= result_valid_d;
      result_ch_q    <= result_ch_d;
      result_data_q  <= result_data_d;
      scan_done_q    <= scan_done_d;
      active_q       <= active_d;
      fault_q        <= fault_d;
      if (tbl_we) table_q[tbl_waddr] <= tbl_wdata;
    end
  end

  assign mo_load      = mo_load_q;
  assign mo_data      = mo_data_q;
  assign result_valid = result_valid_q;
  assign result_ch    = result_ch_q;
  assign result_data  = result_data_q;
  assign scan_done    = scan_done_q;
  assign active       = active_q;
  assign fault        = fault_q;
  assign rd_data      = table_q[rd_addr];

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: SPI master model with a pipelined ADC response
// plus a list-based model of the expected frame and result sequence.
module tb_adc_scan_sequencer;

  localparam int unsigned TB_GAP = 5;
  localparam int unsigned PERIOD = 19 + TB_GAP;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic [15:0] mo_data;
  logic        mo_load;
  logic        busy = 1'b0;
  logic [15:0] mi_data = 16'h0000;
  logic        result_valid;
  logic [2:0]  result_ch;
  logic [11:0] result_data;
  logic [2:0]  rd_addr = 3'd0;
  logic [11:0] rd_data;
  logic        scan_done;
  logic        active;
  logic        fault;

  adc_scan_sequencer #(.GAP(TB_GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .cont(cont), .ch_mask(ch_mask),
    .mo_data(mo_data), .mo_load(mo_load), .busy(busy), .mi_data(mi_data),
    .result_valid(result_valid), .result_ch(result_ch), .result_data(result_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .scan_done(scan_done),
    .active(active), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Master: busy for 16 bit clocks, returns {salt, address of the previous frame}.
  logic [4:0]  mcnt = 5'd0;
  logic [2:0]  mprev = 3'd0;
  logic [11:0] mresp = 12'h000;
  logic [8:0]  salt = 9'h000;
  bit          never_busy = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      mcnt  <= 5'd0;
      mprev <= 3'd0;
    end else if (mo_load && !never_busy) begin
      busy  <= 1'b1;
      mcnt  <= 5'd17;
      mresp <= {salt, mprev};
      mprev <= mo_data[13:11];
    end else if (mcnt != 5'd0) begin
      mcnt <= mcnt - 5'd1;
      if (mcnt == 5'd1) begin
        busy    <= 1'b0;
        mi_data <= {4'h0, mresp};
      end
    end
  end

  logic [15:0] load_d[$];
  int          load_t[$];
  logic [14:0] res_q[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (mo_load) begin
        load_d.push_back(mo_data);
        load_t.push_back(cyc);
      end
      if (result_valid) res_q.push_back({result_ch, result_data});
      if (scan_done) done_cnt <= done_cnt + 1;
    end
  end

  logic [2:0]  exp_a[$];
  logic [14:0] exp_r[$];
  logic [11:0] tbl_m [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    load_d.delete(); load_t.delete(); res_q.delete();
    exp_a.delete(); exp_r.delete();
  endtask

  // One scan from the rules: frame list from the enabled channels, one result per channel.
  task automatic model_scan(input logic [7:0] m, input bit first, input logic [8:0] s);
    int ch[$];
    for (int i = 0; i < 8; i++) if (m[i]) ch.push_back(i);
    if (first) foreach (ch[k]) exp_a.push_back(3'(ch[k]));
    else for (int k = 1; k < ch.size(); k++) exp_a.push_back(3'(ch[k]));
    exp_a.push_back(3'(ch[0]));
    foreach (ch[k]) begin
      exp_r.push_back({3'(ch[k]), s, 3'(ch[k])});
      tbl_m[ch[k]] = {s, 3'(ch[k])};
    end
  endtask

  task automatic compare_logs(input string tag);
    check({tag, " nloads"}, load_d.size(), exp_a.size());
    for (int k = 0; k < load_d.size() && k < exp_a.size(); k++)
      check($sformatf("%s mo_data%0d", tag, k), load_d[k], {2'b00, exp_a[k], 11'b0});
    for (int k = 1; k < load_t.size(); k++)
      check($sformatf("%s period%0d", tag, k), load_t[k] - load_t[k-1], PERIOD);
    check({tag, " nresults"}, res_q.size(), exp_r.size());
    for (int k = 0; k < res_q.size() && k < exp_r.size(); k++)
      check($sformatf("%s result%0d", tag, k), res_q[k], exp_r[k]);
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      check($sformatf("%s tbl%0d", tag, i), rd_data, tbl_m[i]);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " mo_load"}, mo_load, 0);
    check({tag, " mo_data"}, mo_data, 0);
    check({tag, " result_valid"}, result_valid, 0);
    check({tag, " result_ch"}, result_ch, 0);
    check({tag, " result_data"}, result_data, 0);
    check({tag, " scan_done"}, scan_done, 0);
    check({tag, " active"}, active, 0);
    check({tag, " fault"}, fault, 0);
  endtask

  task automatic pulse_start(input logic [7:0] m);
    @(negedge clk);
    ch_mask = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " scan_done count"}, done_cnt, target);
  endtask

  task automatic wait_load(input string tag);
    int n = 0;
    while (mo_load !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " mo_load seen"}, mo_load, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] m;
    logic [8:0] s;
    int base;

    foreach (tbl_m[i]) tbl_m[i] = 12'h000;

    // Reset state while reset is held, then idle after release.
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    check_table("reset");
    repeat (10) @(negedge clk);
    check("idle nloads", load_d.size(), 0);

    // Basic single scan, mask 05; a start mid-scan must be ignored.
    clear_logs();
    base = done_cnt;
    salt = 9'h140;
    cont = 1'b0;
    pulse_start(8'h05);
    model_scan(8'h05, 1'b1, salt);
    repeat (5) @(negedge clk);
    pulse_start(8'hFF);
    wait_done("basic", base + 1, 400);
    repeat (30) @(negedge clk);
    compare_logs("basic");
    check("basic done stable", done_cnt, base + 1);
    check("basic active", active, 0);
    rd_addr = 3'd0; #1;
    check("basic tbl0 const", rd_data, 12'hA00);
    rd_addr = 3'd2; #1;
    check("basic tbl2 const", rd_data, 12'hA02);

    // Continuous with a mask change at scan end: restart with discard.
    clear_logs();
    base = done_cnt;
    salt = 9'($urandom);
    cont = 1'b1;
    pulse_start(8'h80);
    repeat (5) @(negedge clk);
    ch_mask = 8'h81;
    model_scan(8'h80, 1'b1, salt);
    model_scan(8'h81, 1'b1, salt);
    wait_done("mchg", base + 1, 400);
    cont = 1'b0;
    wait_done("mchg", base + 2, 600);
    repeat (30) @(negedge clk);
    compare_logs("mchg");
    check_table("mchg");

    // Random masks: first scan then one continuous scan with the same mask.
    for (int it = 0; it < 4; it++) begin
      clear_logs();
      base = done_cnt;
      m = 8'($urandom_range(1, 255));
      s = 9'($urandom);
      salt = s;
      cont = 1'b1;
      pulse_start(m);
      model_scan(m, 1'b1, s);
      model_scan(m, 1'b0, s);
      wait_done($sformatf("rnd%0d", it), base + 1, 600);
      cont = 1'b0;
      wait_done($sformatf("rnd%0d", it), base + 2, 600);
      repeat (30) @(negedge clk);
      compare_logs($sformatf("rnd%0d m=%02h", it, m));
      check_table($sformatf("rnd%0d", it));
    end

    // Start with an empty mask does nothing.
    clear_logs();
    pulse_start(8'h00);
    repeat (40) @(negedge clk);
    check("zmask nloads", load_d.size(), 0);
    check("zmask active", active, 0);

    // Master never goes busy: fault and idle three clocks after mo_load.
    clear_logs();
    base = done_cnt;
    never_busy = 1'b1;
    pulse_start(8'h24);
    wait_load("nobusy");
    repeat (2) @(negedge clk);
    check("nobusy t2 active", active, 1);
    check("nobusy t2 fault", fault, 0);
    @(negedge clk);
    check("nobusy t3 fault", fault, 1);
    check("nobusy t3 active", active, 0);
    repeat (30) @(negedge clk);
    check("nobusy no scan_done", done_cnt, base);
    check("nobusy nloads", load_d.size(), 1);
    never_busy = 1'b0;
    clear_logs();
    salt = 9'($urandom);
    pulse_start(8'h42);
    check("fault cleared", fault, 0);
    model_scan(8'h42, 1'b1, salt);
    wait_done("after fault", base + 1, 400);
    repeat (30) @(negedge clk);
    compare_logs("after fault");

    // Reset during XFER clears everything and nothing follows.
    clear_logs();
    base = done_cnt;
    pulse_start(8'h0F);
    wait_load("midrst");
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    check_outputs_zero("midrst async");
    @(negedge clk);
    check_outputs_zero("midrst clk");
    foreach (tbl_m[i]) tbl_m[i] = 12'h000;
    check_table("midrst");
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("midrst no result", res_q.size(), 0);
    check("midrst no load", load_d.size(), 1);
    check("midrst no done", done_cnt, base);
    check("midrst active", active, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
